fp_addsub_mc: RTL

- Parametrised, multi-cycle IEEE-754-style floating-point adder/subtractor for the FP datapath of the multi-cycle core.
- Replaces the single-precision combinational adder with:
  - configurable exponent and mantissa widths
  - an add/sub mode
  - magnitude-ordered operand swap
  - leading-zero normalisation
  - round-to-nearest-even
  - special-value handling and exception flags
- Sits behind the FP register file and uses a valid/ready handshake on both sides.

---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp_lzc.sv | 19 +
 rtl/fp_addsub_mc.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the multi-cycle floating-point adder/subtractor:
// default widths, bias helper, canonical special encodings, flag indices, FSM states.
package fp_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;
    localparam int DEF_W     = 1 + DEF_EXP_W + DEF_MAN_W;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    localparam logic [DEF_W-1:0] DEF_QNAN = {1'b0, {DEF_EXP_W{1'b1}}, 1'b1, {(DEF_MAN_W-1){1'b0}}};
    localparam logic [DEF_W-1:0] DEF_INF  = {1'b0, {DEF_EXP_W{1'b1}}, {DEF_MAN_W{1'b0}}};

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } state_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter over the MAN_W+5 bit adder sum.
module fp_lzc #(
    parameter int MAN_W = 23,
    localparam int N  = MAN_W + 5,
    localparam int CW = $clog2(MAN_W + 6)
) (
    input  logic [N-1:0]  value,
    output logic [CW-1:0] count
);

    // Highest set bit wins because it is visited last; all-zero reports N.
    always_comb begin
        count = CW'(N);
        for (int i = 0; i < N; i++) begin
            if (value[i]) count = CW'(N - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_mc.sv
// Multi-cycle FP add/sub: one stage per FSM state, RNE rounding, flush-to-zero,
// special values resolved at unpack and carried to the output slot.
module fp_addsub_mc
    import fp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    parameter int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);

    localparam int EXT  = MAN_W + 4;
    localparam int SUMW = MAN_W + 5;
    localparam int XW   = EXP_W + 2;
    localparam int LZW  = $clog2(MAN_W + 6);
    localparam int MAGW = EXP_W + MAN_W;
    localparam logic [EXP_W-1:0]    EXP_ONES = '1;
    localparam logic [W-1:0]        QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] ONE_S   = XW'(1);

    state_t state, state_nx;

    logic [W-1:0]            a_r, b_r;
    logic                    sign_r, eff_sub_r, special_r, zero_r;
    logic [W-1:0]            spec_res_r;
    logic [3:0]              spec_flags_r;
    logic [EXP_W-1:0]        x_exp_r, y_exp_r;
    logic [EXT-1:0]          x_ext_r, y_ext_r, y_al_r, norm_r;
    logic [SUMW-1:0]         sum_r;
    logic signed [XW-1:0]    exp_r;
    logic [W-1:0]            result_r;
    logic [3:0]              flags_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (in_valid) state_nx = ST_UNPACK;
            ST_UNPACK: state_nx = ST_ALIGN;
            ST_ALIGN:  state_nx = ST_ADD;
            ST_ADD:    state_nx = ST_NORM;
            ST_NORM:   state_nx = ST_ROUND;
            ST_ROUND:  state_nx = ST_DONE;
            ST_DONE:   if (out_ready) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign result    = result_r;
    assign flags     = flags_r;

    // Unpack: classify, flush denormals, order by magnitude.
    logic             sa, sb, sx, sy;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
    logic [MAGW-1:0]  mag_a, mag_b, mag_x, mag_y;
    logic             sp;
    logic [W-1:0]     sp_res;
    logic [3:0]       sp_flags;

    assign {sa, ea, fa} = a_r;
    assign {sb, eb, fb} = b_r;
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign mag_a  = a_zero ? '0 : {ea, fa};
    assign mag_b  = b_zero ? '0 : {eb, fb};
    assign swap   = (mag_b > mag_a);
    assign mag_x  = swap ? mag_b : mag_a;
    assign mag_y  = swap ? mag_a : mag_b;
    assign sx     = swap ? sb : sa;
    assign sy     = swap ? sa : sb;

    always_comb begin
        sp       = 1'b1;
        sp_res   = '0;
        sp_flags = '0;
        if (a_nan || b_nan) begin
            sp_res = QNAN;
        end else if (a_inf && b_inf && (sa != sb)) begin
            sp_res                 = QNAN;
            sp_flags[FLAG_INVALID] = 1'b1;
        end else if (a_inf) begin
            sp_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            sp_res = {sb, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            sp_res = {sa & sb, {(W-1){1'b0}}};
        end else begin
            sp = 1'b0;
        end
    end

    // Align: a shift of MAN_W+3 or more leaves only the sticky bit set.
    logic [EXP_W-1:0] d;
    logic [EXT-1:0]   lost_mask, y_al_nx;
    logic             sticky;

    assign d         = x_exp_r - y_exp_r;
    assign lost_mask = ~({EXT{1'b1}} << d);
    assign sticky    = |(y_ext_r & lost_mask);
    assign y_al_nx   = (y_ext_r >> d) | {{(EXT-1){1'b0}}, sticky};

    logic [SUMW-1:0] sum_nx;
    assign sum_nx = eff_sub_r ? ({1'b0, x_ext_r} - {1'b0, y_al_r})
                              : ({1'b0, x_ext_r} + {1'b0, y_al_r});

    // Normalise: leading one lands at EXT-1; exponent tracks the carry slot.
    logic [LZW-1:0]       lz;
    logic [SUMW-1:0]      sum_shl;
    logic [EXT-1:0]       norm_nx;
    logic signed [XW-1:0] exp_x_s, lz_s, exp_nx;

    fp_lzc #(.MAN_W(MAN_W)) u_lzc (
        .value (sum_r),
        .count (lz)
    );

    assign exp_x_s = $signed({2'b00, x_exp_r});
    assign lz_s    = $signed({{(XW-LZW){1'b0}}, lz});
    assign sum_shl = sum_r << lz;

    always_comb begin
        if (sum_r[SUMW-1]) begin
            norm_nx = {sum_r[SUMW-1:2], sum_r[1] | sum_r[0]};
            exp_nx  = exp_x_s + ONE_S;
        end else begin
            norm_nx = sum_shl[SUMW-1:1];
            exp_nx  = exp_x_s + ONE_S - lz_s;
        end
    end

    // Round to nearest even, then range-check the exponent.
    logic [MAN_W:0]       mant;
    logic [MAN_W+1:0]     mant_inc;
    logic [MAN_W-1:0]     frac_fin;
    logic                 g, r, s, inc, inexact, m_ovf;
    logic signed [XW-1:0] exp_fin;
    logic [W-1:0]         res_nx;
    logic [3:0]           flg_nx;

    assign mant     = norm_r[EXT-1:3];
    assign g        = norm_r[2];
    assign r        = norm_r[1];
    assign s        = norm_r[0];
    assign inc      = g & (r | s | mant[0]);
    assign inexact  = g | r | s;
    assign mant_inc = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};
    assign m_ovf    = mant_inc[MAN_W+1];
    assign frac_fin = m_ovf ? mant_inc[MAN_W:1] : mant_inc[MAN_W-1:0];
    assign exp_fin  = exp_r + $signed({{(XW-1){1'b0}}, m_ovf});

    always_comb begin
        res_nx = {sign_r, exp_fin[EXP_W-1:0], frac_fin};
        flg_nx = '0;
        flg_nx[FLAG_INEXACT] = inexact;
        if (special_r) begin
            res_nx = spec_res_r;
            flg_nx = spec_flags_r;
        end else if (zero_r) begin
            res_nx = '0;
            flg_nx = '0;
        end else if (exp_fin >= EXP_MAX) begin
            res_nx = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
            flg_nx = '0;
            flg_nx[FLAG_OVERFLOW] = 1'b1;
            flg_nx[FLAG_INEXACT]  = 1'b1;
        end else if (exp_fin[XW-1] || (exp_fin == '0)) begin
            res_nx = {sign_r, {(W-1){1'b0}}};
            flg_nx = '0;
            flg_nx[FLAG_UNDERFLOW] = 1'b1;
            flg_nx[FLAG_INEXACT]   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r          <= '0;
            b_r          <= '0;
            sign_r       <= 1'b0;
            eff_sub_r    <= 1'b0;
            special_r    <= 1'b0;
            zero_r       <= 1'b0;
            spec_res_r   <= '0;
            spec_flags_r <= '0;
            x_exp_r      <= '0;
            y_exp_r      <= '0;
            x_ext_r      <= '0;
            y_ext_r      <= '0;
            y_al_r       <= '0;
            sum_r        <= '0;
            norm_r       <= '0;
            exp_r        <= '0;
            result_r     <= '0;
            flags_r      <= '0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    a_r <= a;
                    b_r <= {b[W-1] ^ op_sub, b[W-2:0]};
                end
                ST_UNPACK: begin
                    sign_r       <= sx;
                    eff_sub_r    <= sx ^ sy;
                    special_r    <= sp;
                    spec_res_r   <= sp_res;
                    spec_flags_r <= sp_flags;
                    x_exp_r      <= mag_x[MAGW-1:MAN_W];
                    y_exp_r      <= mag_y[MAGW-1:MAN_W];
                    x_ext_r      <= {mag_x[MAGW-1:MAN_W] != '0, mag_x[MAN_W-1:0], 3'b000};
                    y_ext_r      <= {mag_y[MAGW-1:MAN_W] != '0, mag_y[MAN_W-1:0], 3'b000};
                end
                ST_ALIGN: y_al_r <= y_al_nx;
                ST_ADD:   sum_r  <= sum_nx;
                ST_NORM: begin
                    norm_r <= norm_nx;
                    exp_r  <= exp_nx;
                    zero_r <= (sum_r == '0);
                end
                ST_ROUND: begin
                    result_r <= res_nx;
                    flags_r  <= flg_nx;
                end
                default: ;
            endcase
        end
    end

endmodule
